// File: rtl/ram_byte_responder.sv
// Byte-wide RAM bus responder: backing RAM, TX/RX byte FIFOs and a halt flag in a small MMIO window.
// Define IO_STATUS_EN to expose a status byte at offset 4 and a TX-overflow clear at offset 5.
module ram_byte_responder #(
  parameter int unsigned MEM_ADDR_W     = 17,
  parameter int unsigned FIFO_DEPTH_LOG = 3,
  parameter logic [31:0] IO_BASE        = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] ram_adr_i,
  input  logic        ram_rwen_i,
  input  logic [7:0]  ram_dat_i,
  output logic [7:0]  ram_dat_o,
  output logic        io_full_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_dat_o,
  input  logic        tx_ready_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_dat_i,
  output logic        halt_o
);

  localparam int unsigned DEPTH     = 1 << FIFO_DEPTH_LOG;
  localparam int unsigned PW        = FIFO_DEPTH_LOG;
  localparam int unsigned CW        = FIFO_DEPTH_LOG + 1;
  localparam int unsigned MEM_BYTES = 1 << MEM_ADDR_W;

  // Bus decode
  logic                  io_sel;
  logic [2:0]            io_off;
  logic                  wr_req;
  logic                  rd_req;
  logic                  mem_wr;
  logic [MEM_ADDR_W-1:0] mem_adr;
  logic [7:0]            mem_rd;

  assign io_sel  = (ram_adr_i[31:3] == IO_BASE[31:3]);
  assign io_off  = ram_adr_i[2:0];
  assign wr_req  = en & ram_rwen_i;
  assign rd_req  = en & ~ram_rwen_i;
  assign mem_wr  = wr_req & ~io_sel;
  assign mem_adr = ram_adr_i[MEM_ADDR_W-1:0];

  // Backing RAM: contents survive reset, so no reset on the array
  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_adr] <= ram_dat_i;
    end
  end

  assign mem_rd = mem[mem_adr];

  // TX FIFO (bus pushes, host pops)
  logic [7:0]    tx_buf [DEPTH];
  logic [PW-1:0] tx_wp_q, tx_wp_d;
  logic [PW-1:0] tx_rp_q, tx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push_req;
  logic          tx_push;
  logic          tx_pop;

  assign tx_full     = (tx_cnt_q == CW'(DEPTH));
  assign tx_empty    = (tx_cnt_q == CW'(0));
  assign tx_push_req = wr_req & io_sel & (io_off == 3'd0);
  assign tx_pop      = tx_ready_i & ~tx_empty;
  // A full FIFO still accepts a push when the host pops in the same cycle
  assign tx_push     = tx_push_req & (~tx_full | tx_pop);

  always_comb begin
    tx_wp_d  = tx_wp_q + PW'(tx_push);
    tx_rp_d  = tx_rp_q + PW'(tx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
  end

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_buf[tx_wp_q] <= ram_dat_i;
    end
  end

  assign tx_valid_o = ~tx_empty;
  assign tx_dat_o   = tx_empty ? 8'h00 : tx_buf[tx_rp_q];

  // RX FIFO (host pushes, bus reads at offset 0 pop)
  logic [7:0]    rx_buf [DEPTH];
  logic [PW-1:0] rx_wp_q, rx_wp_d;
  logic [PW-1:0] rx_rp_q, rx_rp_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_pop_req;
  logic          rx_pop;
  logic          rx_push;
  logic [7:0]    rx_head;

  assign rx_full    = (rx_cnt_q == CW'(DEPTH));
  assign rx_empty   = (rx_cnt_q == CW'(0));
  assign rx_pop_req = rd_req & io_sel & (io_off == 3'd0);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_push    = rx_valid_i & (~rx_full | rx_pop);
  assign rx_head    = rx_buf[rx_rp_q];

  always_comb begin
    rx_wp_d  = rx_wp_q + PW'(rx_push);
    rx_rp_d  = rx_rp_q + PW'(rx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  end

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_buf[rx_wp_q] <= rx_dat_i;
    end
  end

  // Read data, halt flag and back-pressure next state
  logic [7:0] ram_dat_q, ram_dat_d;
  logic       halt_q, halt_d;
  logic       io_full_q, io_full_d;

`ifdef IO_STATUS_EN
  logic       tx_ovf_q, tx_ovf_d;
  logic [7:0] io_status;

  assign io_status = {4'b0000, tx_ovf_q, rx_full, tx_full, ~rx_empty};

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    if (wr_req && io_sel && (io_off == 3'd5)) begin
      tx_ovf_d = 1'b0;
    end
    if (tx_push_req && !tx_push) begin
      tx_ovf_d = 1'b1;
    end
  end
`endif

  always_comb begin
    ram_dat_d = ram_dat_q;
    halt_d    = halt_q | (wr_req & io_sel & (io_off == 3'd4));
    io_full_d = (tx_cnt_d >= CW'(DEPTH - 2));
    if (rd_req) begin
      if (!io_sel) begin
        ram_dat_d = mem_rd;
      end else begin
        case (io_off)
          3'd0:    ram_dat_d = rx_empty ? 8'h00 : rx_head;
`ifdef IO_STATUS_EN
          3'd4:    ram_dat_d = io_status;
`endif
          default: ram_dat_d = 8'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_dat_q <= 8'h00;
      halt_q    <= 1'b0;
      io_full_q <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
`ifdef IO_STATUS_EN
      tx_ovf_q  <= 1'b0;
`endif
    end else begin
      ram_dat_q <= ram_dat_d;
      halt_q    <= halt_d;
      io_full_q <= io_full_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
`ifdef IO_STATUS_EN
      tx_ovf_q  <= tx_ovf_d;
`endif
    end
  end

  assign ram_dat_o = ram_dat_q;
  assign halt_o    = halt_q;
  assign io_full_o = io_full_q;

endmodule

// File: doc/ram_byte_responder.md
Name: ram_byte_responder

Overview:
- Responder end of the byte-wide RAM bus that the memory IO controller drives.
- Accepts one byte access per cycle: address, read/write enable and write data.
- Reads complete with exactly one cycle of latency; writes complete in the same cycle.
- Decodes a small MMIO window: a TX FIFO toward the host/UART side, an RX FIFO from it, and a halt register. It also raises back-pressure when the TX FIFO is nearly full.

Parameters:
- MEM_ADDR_W, 17: byte-address width of the backing RAM (2^17 bytes).
- FIFO_DEPTH_LOG, 3: log2 of the TX and RX FIFO depth (8 entries each).
- IO_BASE, 32'h0003_0000: MMIO window base; the window is IO_BASE..IO_BASE+7.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- en  in  1  access valid this cycle; when 0 nothing is read, written, pushed or popped
- ram_adr_i  in  32  byte address from the controller
- ram_rwen_i  in  1  1 = write, 0 = read
- ram_dat_i  in  8  write data
- ram_dat_o  out  8  read data, valid the cycle after the address
- io_full_o  out  1  TX FIFO has 2 or fewer free entries (back-pressure to the controller)
- tx_valid_o  out  1  TX FIFO non-empty
- tx_dat_o  out  8  TX FIFO head byte
- tx_ready_i  in  1  host consumes the TX head when tx_valid_o=1
- rx_valid_i  in  1  host pushes rx_dat_i
- rx_dat_i  in  8  host byte
- halt_o  out  1  sticky program-end flag

Behaviour:
- Reset (rst=0, async): ram_dat_o=0, io_full_o=0, tx_valid_o=0, tx_dat_o=0, halt_o=0; both FIFOs empty with pointers and counts at 0. RAM contents are not cleared. A reset in mid-access drops the pending read data.
- Address decode: io_sel = (ram_adr_i[31:3] == IO_BASE[31:3]). If io_sel=0, the access goes to RAM at ram_adr_i[MEM_ADDR_W-1:0]; higher bits are ignored (aliasing).
- RAM write (en, rwen=1, !io_sel): mem[a] <= ram_dat_i at this posedge.
- RAM read (en, rwen=0, !io_sel): ram_dat_o <= mem[a] at this posedge, so data is visible in cycle N+1 for an address in cycle N.
- Read-after-write to the same byte in consecutive cycles returns the new value.
- ram_dat_o holds its value on cycles with no read.
- MMIO offset 0, write: push ram_dat_i into the TX FIFO. If the FIFO is full the byte is dropped and a sticky internal tx_overflow bit is set; that bit is only readable via the optional feature.
- MMIO offset 0, read: ram_dat_o <= RX head and pop, with the same 1-cycle latency. If RX is empty, ram_dat_o <= 8'h00 and no pop occurs.
- MMIO offset 4, write: halt_o <= 1 (sticky until reset).
- Any other MMIO offset: writes are ignored; reads return 8'h00.
- TX FIFO:
  - Circular buffer with a count register.
  - Push and pop in the same cycle leave the count unchanged. When the FIFO is full, a simultaneous push and pop is accepted.
  - tx_dat_o/tx_valid_o are combinational from the head.
  - Pointers wrap modulo 2^FIFO_DEPTH_LOG.
- RX FIFO:
  - Same structure as the TX FIFO.
  - rx_valid_i when full drops the byte.
  - A host push and a bus pop in the same cycle are both honoured. If RX was empty, the popped value is 8'h00 and the pushed byte stays.
- io_full_o is registered: it is updated from the post-update TX count, high when count >= depth-2. The controller can therefore see it before issuing the next store.
- en=0: no state change except host-side TX pop and RX push, which are independent of en.

Optional Feature:
- Macro IO_STATUS_EN.
- Defined: a read at MMIO offset 4 returns {4'b0, tx_overflow, rx_full, tx_full, rx_nonempty}, and a write at offset 5 clears tx_overflow.
- Not defined: offset 4 reads return 8'h00, offset 5 writes are ignored, and tx_overflow logic is removed.

Test Plan:
- Write 8'hA5 to 0x0000_1234, read it next cycle -> ram_dat_o=8'hA5 exactly one cycle after the read address; ram_dat_o unchanged on the following idle cycle.
- Write 0x11,0x22,0x33,0x44 to 0x100..0x103, then read back-to-back over 4 cycles -> 0x11,0x22,0x33,0x44 in cycles N+1..N+4.
- 6 writes to 0x30000 with tx_ready_i=0 -> io_full_o=1 after the 6th push; 2 more writes fill the FIFO; a 9th is dropped; draining gives bytes in order, 8 total.
- Host pushes 0x5A, bus reads 0x30000 twice -> 0x5A then 0x00; RX empty afterwards.
- Write to 0x30004 -> halt_o=1 next cycle. Assert rst=0 asynchronously mid-burst -> all outputs 0 immediately; RAM byte written earlier still reads back.
- With IO_STATUS_EN: overflow the TX FIFO, read 0x30004 -> bit3=1 and bit1=1; write 0x30005, re-read after draining -> 8'h00.
